// File: rtl/alu_issue_stage.sv
// ALU issue stage: decodes ALU-class RV32I instructions (OP, OP-IMM, LUI,
// AUIPC) into an ALU op code plus operands and holds the result in a
// single valid/ready pipeline register feeding the execute stage.
module alu_issue_stage #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    input  logic [XLEN-1:0] in_rs1_data,
    input  logic [XLEN-1:0] in_rs2_data,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_a,
    output logic [XLEN-1:0] out_b,
    output logic [3:0]      out_alu_op,
    output logic [4:0]      out_rd,
    output logic            out_reg_write,
    output logic            out_illegal
);

    typedef enum logic [3:0] {
        ALU_ADD  = 4'b0000,
        ALU_SUB  = 4'b0001,
        ALU_XOR  = 4'b0010,
        ALU_OR   = 4'b0011,
        ALU_AND  = 4'b0100,
        ALU_SLL  = 4'b0101,
        ALU_SRL  = 4'b0110,
        ALU_SRA  = 4'b0111,
        ALU_SLT  = 4'b1000,
        ALU_SLTU = 4'b1001
    } alu_op_e;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    logic [6:0]      opcode;
    logic [2:0]      f3;
    logic [6:0]      f7;
    logic            f7_base;
    logic            f7_alt;
    logic [XLEN-1:0] imm_i;
    logic [XLEN-1:0] imm_u;

    alu_op_e         dec_op;
    logic            dec_legal;
    logic [XLEN-1:0] dec_a;
    logic [XLEN-1:0] dec_b;

    logic            capture;

    assign opcode  = in_instr[6:0];
    assign f3      = in_instr[14:12];
    assign f7      = in_instr[31:25];
    assign f7_base = (f7 == F7_BASE);
    assign f7_alt  = (f7 == F7_ALT);

    // Shift immediates keep the whole sign-extended field; the ALU only
    // looks at b[4:0], so no separate shamt path is needed.
    assign imm_i = {{(XLEN-12){in_instr[31]}}, in_instr[31:20]};
    assign imm_u = {in_instr[31:12], 12'b0};

    // Op-code selection and legality check for the ALU-class opcodes.
    always_comb begin
        dec_op    = ALU_ADD;
        dec_legal = 1'b0;
        case (opcode)
            OPC_OP: begin
                case (f3)
                    3'b000: begin
                        dec_legal = f7_base || f7_alt;
                        dec_op    = f7_alt ? ALU_SUB : ALU_ADD;
                    end
                    3'b001: begin
                        dec_legal = f7_base;
                        dec_op    = ALU_SLL;
                    end
                    3'b010: begin
                        dec_legal = f7_base;
                        dec_op    = ALU_SLT;
                    end
                    3'b011: begin
                        dec_legal = f7_base;
                        dec_op    = ALU_SLTU;
                    end
                    3'b100: begin
                        dec_legal = f7_base;
                        dec_op    = ALU_XOR;
                    end
                    3'b101: begin
                        dec_legal = f7_base || f7_alt;
                        dec_op    = f7_alt ? ALU_SRA : ALU_SRL;
                    end
                    3'b110: begin
                        dec_legal = f7_base;
                        dec_op    = ALU_OR;
                    end
                    default: begin
                        dec_legal = f7_base;
                        dec_op    = ALU_AND;
                    end
                endcase
            end
            OPC_OP_IMM: begin
                case (f3)
                    3'b000: begin
                        dec_legal = 1'b1;
                        dec_op    = ALU_ADD;
                    end
                    3'b001: begin
                        dec_legal = f7_base;
                        dec_op    = ALU_SLL;
                    end
                    3'b010: begin
                        dec_legal = 1'b1;
                        dec_op    = ALU_SLT;
                    end
                    3'b011: begin
                        dec_legal = 1'b1;
                        dec_op    = ALU_SLTU;
                    end
                    3'b100: begin
                        dec_legal = 1'b1;
                        dec_op    = ALU_XOR;
                    end
                    3'b101: begin
                        dec_legal = f7_base || f7_alt;
                        dec_op    = f7_alt ? ALU_SRA : ALU_SRL;
                    end
                    3'b110: begin
                        dec_legal = 1'b1;
                        dec_op    = ALU_OR;
                    end
                    default: begin
                        dec_legal = 1'b1;
                        dec_op    = ALU_AND;
                    end
                endcase
            end
            OPC_LUI, OPC_AUIPC: begin
                dec_legal = 1'b1;
                dec_op    = ALU_ADD;
            end
            default: begin
                dec_legal = 1'b0;
                dec_op    = ALU_ADD;
            end
        endcase
        // Illegal encodings issue as a harmless add of zeros.
        if (!dec_legal) begin
            dec_op = ALU_ADD;
        end
    end

    // Operand A/B selection; illegal encodings leave both operands zero.
    always_comb begin
        dec_a = '0;
        dec_b = '0;
        if (dec_legal) begin
            case (opcode)
                OPC_OP: begin
                    dec_a = in_rs1_data;
                    dec_b = in_rs2_data;
                end
                OPC_OP_IMM: begin
                    dec_a = in_rs1_data;
                    dec_b = imm_i;
                end
                OPC_LUI: begin
                    dec_a = '0;
                    dec_b = imm_u;
                end
                OPC_AUIPC: begin
                    dec_a = in_pc;
                    dec_b = imm_u;
                end
                default: begin
                    dec_a = '0;
                    dec_b = '0;
                end
            endcase
        end
    end

    // The register can take a new instruction whenever it is empty or its
    // current content leaves this cycle, giving full throughput.
    assign in_ready = !out_valid || out_ready;
    assign capture  = in_valid && in_ready && !flush;

    // Valid bit: reset, then flush, then capture, then drain on handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (capture) begin
            out_valid <= 1'b1;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // Payload register: loads only on capture, so it stays stable while stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_a         <= '0;
            out_b         <= '0;
            out_alu_op    <= 4'b0000;
            out_rd        <= 5'd0;
            out_reg_write <= 1'b0;
            out_illegal   <= 1'b0;
        end else if (capture) begin
            out_a         <= dec_a;
            out_b         <= dec_b;
            out_alu_op    <= dec_op;
            out_rd        <= in_instr[11:7];
            out_reg_write <= dec_legal;
            out_illegal   <= !dec_legal;
        end
    end

endmodule

// File: tb/tb_alu_issue_stage.sv
// Self-checking bench for alu_issue_stage: directed vectors, backpressure,
// flush, mid-stall reset and a randomized run against a reference model.
module tb_alu_issue_stage;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  op;
        logic [4:0]  rd;
        logic        rw;
        logic        ill;
    } dec_t;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic [31:0] in_rs1_data;
    logic [31:0] in_rs2_data;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_a;
    logic [31:0] out_b;
    logic [3:0]  out_alu_op;
    logic [4:0]  out_rd;
    logic        out_reg_write;
    logic        out_illegal;

    int n_checks = 0;
    int n_fail   = 0;

    logic m_valid;
    dec_t m_d;

    alu_issue_stage #(.XLEN(32)) dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_instr      (in_instr),
        .in_pc         (in_pc),
        .in_rs1_data   (in_rs1_data),
        .in_rs2_data   (in_rs2_data),
        .flush         (flush),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_a         (out_a),
        .out_b         (out_b),
        .out_alu_op    (out_alu_op),
        .out_rd        (out_rd),
        .out_reg_write (out_reg_write),
        .out_illegal   (out_illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference decode: legal f7/f3 combinations looked up in a table.
    function automatic dec_t ref_decode(input logic [31:0] ins, input logic [31:0] pc,
                                        input logic [31:0] r1, input logic [31:0] r2);
        dec_t d;
        logic [3:0] tbl [8];
        logic [2:0] f3;
        logic [6:0] f7;
        tbl = '{4'd0, 4'd5, 4'd8, 4'd9, 4'd2, 4'd6, 4'd3, 4'd4};
        f3 = ins[14:12];
        f7 = ins[31:25];
        d = '0;
        d.rd = ins[11:7];
        d.ill = 1'b1;
        if (ins[6:0] == 7'h33) begin
            if (f7 == 7'h00) begin
                d.ill = 1'b0; d.op = tbl[f3];
            end else if (f7 == 7'h20 && f3 == 3'd0) begin
                d.ill = 1'b0; d.op = 4'd1;
            end else if (f7 == 7'h20 && f3 == 3'd5) begin
                d.ill = 1'b0; d.op = 4'd7;
            end
            if (!d.ill) begin
                d.a = r1; d.b = r2;
            end
        end else if (ins[6:0] == 7'h13) begin
            if (f3 != 3'd1 && f3 != 3'd5) begin
                d.ill = 1'b0; d.op = tbl[f3];
            end else if (f7 == 7'h00) begin
                d.ill = 1'b0; d.op = tbl[f3];
            end else if (f7 == 7'h20 && f3 == 3'd5) begin
                d.ill = 1'b0; d.op = 4'd7;
            end
            if (!d.ill) begin
                d.a = r1;
                d.b = 32'(signed'(ins[31:20]));
            end
        end else if (ins[6:0] == 7'h37) begin
            d.ill = 1'b0; d.a = 32'd0; d.b = ins & 32'hFFFFF000;
        end else if (ins[6:0] == 7'h17) begin
            d.ill = 1'b0; d.a = pc; d.b = ins & 32'hFFFFF000;
        end
        d.rw = !d.ill;
        return d;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        int k;
        int s;
        w = $urandom;
        k = $urandom_range(0, 9);
        s = $urandom_range(0, 3);
        if (k <= 2)      w[6:0] = 7'h33;
        else if (k <= 5) w[6:0] = 7'h13;
        else if (k == 6) w[6:0] = 7'h37;
        else if (k == 7) w[6:0] = 7'h17;
        if (s <= 1)      w[31:25] = 7'h00;
        else if (s == 2) w[31:25] = 7'h20;
        return w;
    endfunction

    task automatic set_in(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                          input logic [31:0] r1, input logic [31:0] r2,
                          input logic fl, input logic ordy);
        in_valid    = v;
        in_instr    = ins;
        in_pc       = pc;
        in_rs1_data = r1;
        in_rs2_data = r2;
        flush       = fl;
        out_ready   = ordy;
    endtask

    // Advance one clock and update the reference register state.
    task automatic step();
        logic cap;
        dec_t nd;
        cap = in_valid && (!m_valid || out_ready) && !flush;
        nd  = ref_decode(in_instr, in_pc, in_rs1_data, in_rs2_data);
        @(posedge clk);
        if (rst) begin
            m_valid = 1'b0;
            m_d     = '0;
        end else if (flush) begin
            m_valid = 1'b0;
        end else if (cap) begin
            m_valid = 1'b1;
            m_d     = nd;
        end else if (out_ready) begin
            m_valid = 1'b0;
        end
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        set_in(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
        step();
        step();
        n_checks++;
        if ({out_valid, out_a, out_b, out_alu_op, out_rd, out_reg_write, out_illegal} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got valid=%0b a=%h b=%h op=%h rd=%0d rw=%0b ill=%0b, need all 0",
                     out_valid, out_a, out_b, out_alu_op, out_rd, out_reg_write, out_illegal);
        end
        rst = 1'b0;
        step();
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release: got in_ready=%0b out_valid=%0b, need 1/0", in_ready, out_valid);
        end
    endtask

    task automatic test_directed();
        logic [31:0] v_ins [9] = '{32'h002081B3, 32'h402081B3, 32'h40335293, 32'hFFF00093,
                                   32'h123450B7, 32'h12345097, 32'h402091B3, 32'h00000003,
                                   32'h0020B1B3};
        logic [31:0] v_pc  [9] = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10, 32'h100, 32'h18, 32'h1C, 32'h20};
        logic [31:0] v_r1  [9] = '{32'd5, 32'd5, 32'h80000000, 32'd0, 32'd9, 32'd9, 32'd5, 32'd1, 32'd3};
        logic [31:0] v_r2  [9] = '{32'd7, 32'd7, 32'd11, 32'd2, 32'd9, 32'd9, 32'd7, 32'd2, 32'd4};
        logic [31:0] e_a   [9] = '{32'd5, 32'd5, 32'h80000000, 32'd0, 32'd0, 32'h100, 32'd0, 32'd0, 32'd3};
        logic [31:0] e_b   [9] = '{32'd7, 32'd7, 32'h00000403, 32'hFFFFFFFF, 32'h12345000,
                                   32'h12345000, 32'd0, 32'd0, 32'd4};
        logic [3:0]  e_op  [9] = '{4'd0, 4'd1, 4'd7, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd9};
        logic [4:0]  e_rd  [9] = '{5'd3, 5'd3, 5'd5, 5'd1, 5'd1, 5'd1, 5'd3, 5'd0, 5'd3};
        logic        e_ill [9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 9; i++) begin
            set_in(1'b1, v_ins[i], v_pc[i], v_r1[i], v_r2[i], 1'b0, 1'b1);
            step();
            n_checks++;
            if (out_valid !== 1'b1 || out_a !== e_a[i] || out_b !== e_b[i] || out_alu_op !== e_op[i] ||
                out_rd !== e_rd[i] || out_illegal !== e_ill[i] || out_reg_write !== !e_ill[i]) begin
                n_fail++;
                $display("FAIL directed_%0d instr=%h: got v=%0b a=%h b=%h op=%h rd=%0d rw=%0b ill=%0b, need v=1 a=%h b=%h op=%h rd=%0d rw=%0b ill=%0b",
                         i, v_ins[i], out_valid, out_a, out_b, out_alu_op, out_rd, out_reg_write, out_illegal,
                         e_a[i], e_b[i], e_op[i], e_rd[i], !e_ill[i], e_ill[i]);
            end
        end
        set_in(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1);
        step();
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL directed_drain: got out_valid=%0b, need 0", out_valid);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] s_ins [10];
        logic [31:0] s_r1  [10];
        logic [31:0] s_r2  [10];
        dec_t        first;
        dec_t        exp;
        for (int i = 0; i < 10; i++) begin
            s_ins[i] = rand_instr();
            s_r1[i]  = $urandom;
            s_r2[i]  = $urandom;
        end
        first = ref_decode(32'h002081B3, 32'h40, 32'd21, 32'd34);
        set_in(1'b1, 32'h002081B3, 32'h40, 32'd21, 32'd34, 1'b0, 1'b1);
        step();
        for (int c = 0; c < 3; c++) begin
            set_in(1'b1, s_ins[0], 32'h200, s_r1[0], s_r2[0], 1'b0, 1'b0);
            #1;
            n_checks++;
            if (in_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL stall_in_ready cycle %0d: got %0b, need 0", c, in_ready);
            end
            step();
            n_checks++;
            if (out_valid !== 1'b1 || {out_a, out_b, out_alu_op, out_rd, out_reg_write, out_illegal} !== first) begin
                n_fail++;
                $display("FAIL stall_hold cycle %0d: got v=%0b a=%h b=%h op=%h, need v=1 a=%h b=%h op=%h",
                         c, out_valid, out_a, out_b, out_alu_op, first.a, first.b, first.op);
            end
        end
        for (int i = 0; i < 10; i++) begin
            set_in(1'b1, s_ins[i], 32'h200 + 32'(4 * i), s_r1[i], s_r2[i], 1'b0, 1'b1);
            exp = ref_decode(s_ins[i], 32'h200 + 32'(4 * i), s_r1[i], s_r2[i]);
            step();
            n_checks++;
            if (out_valid !== 1'b1 || {out_a, out_b, out_alu_op, out_rd, out_reg_write, out_illegal} !== exp) begin
                n_fail++;
                $display("FAIL stream_%0d instr=%h: got v=%0b a=%h b=%h op=%h rd=%0d ill=%0b, need v=1 a=%h b=%h op=%h rd=%0d ill=%0b",
                         i, s_ins[i], out_valid, out_a, out_b, out_alu_op, out_rd, out_illegal,
                         exp.a, exp.b, exp.op, exp.rd, exp.ill);
            end
        end
        set_in(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1);
        step();
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL stream_no_dup: got out_valid=%0b, need 0", out_valid);
        end
    endtask

    task automatic test_flush();
        set_in(1'b1, 32'h002081B3, 32'h0, 32'd1, 32'd2, 1'b0, 1'b1);
        step();
        set_in(1'b1, 32'h40335293, 32'h4, 32'd3, 32'd4, 1'b1, 1'b0);
        step();
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_kill: got out_valid=%0b, need 0", out_valid);
        end
        set_in(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1);
        step();
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_discard: got out_valid=%0b, need 0", out_valid);
        end
    endtask

    task automatic test_reset_mid_stall();
        set_in(1'b1, 32'h12345097, 32'h100, 32'd0, 32'd0, 1'b0, 1'b1);
        step();
        set_in(1'b1, 32'h002081B3, 32'h104, 32'd5, 32'd7, 1'b0, 1'b0);
        step();
        rst = 1'b1;
        step();
        n_checks++;
        if ({out_valid, out_a, out_b, out_alu_op, out_rd, out_reg_write, out_illegal} !== '0) begin
            n_fail++;
            $display("FAIL reset_mid_stall: got valid=%0b a=%h b=%h op=%h rd=%0d rw=%0b ill=%0b, need all 0",
                     out_valid, out_a, out_b, out_alu_op, out_rd, out_reg_write, out_illegal);
        end
        rst = 1'b0;
        set_in(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
        step();
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_stall_release: got in_ready=%0b out_valid=%0b, need 1/0", in_ready, out_valid);
        end
    endtask

    task automatic test_random();
        logic v;
        logic ordy;
        logic fl;
        for (int c = 0; c < 600; c++) begin
            v    = ($urandom_range(0, 3) != 0);
            ordy = ($urandom_range(0, 2) != 0);
            fl   = ($urandom_range(0, 15) == 0);
            set_in(v, rand_instr(), $urandom, $urandom, $urandom, fl, ordy);
            #1;
            n_checks++;
            if (in_ready !== (!m_valid || ordy)) begin
                n_fail++;
                $display("FAIL rand_in_ready cycle %0d: got %0b, need %0b", c, in_ready, !m_valid || ordy);
            end
            step();
            n_checks++;
            if (out_valid !== m_valid) begin
                n_fail++;
                $display("FAIL rand_valid cycle %0d: got %0b, need %0b", c, out_valid, m_valid);
            end else if (m_valid && {out_a, out_b, out_alu_op, out_rd, out_reg_write, out_illegal} !== m_d) begin
                n_fail++;
                $display("FAIL rand_fields cycle %0d: got a=%h b=%h op=%h rd=%0d rw=%0b ill=%0b, need a=%h b=%h op=%h rd=%0d rw=%0b ill=%0b",
                         c, out_a, out_b, out_alu_op, out_rd, out_reg_write, out_illegal,
                         m_d.a, m_d.b, m_d.op, m_d.rd, m_d.rw, m_d.ill);
            end
        end
    endtask

    initial begin
        m_valid = 1'b0;
        m_d     = '0;
        rst     = 1'b1;
        set_in(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
        test_reset();
        test_directed();
        test_back_to_back();
        test_flush();
        test_reset_mid_stall();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
